// File: rtl/mmio_console.sv
// Memory-mapped console: queues store bytes in a FIFO, drains them on an 8N1 UART
// line, and raises a sticky finish flag once the exit code arrives and the line is drained.
module mmio_console #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CLKS_PER_BIT = 100,
    parameter logic [31:0] FINISH_CODE  = 32'h0002_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dbus_addr_i,
    input  logic        dbus_wvalid_i,
    input  logic [31:0] dbus_wdata_i,
    output logic        stall_o,
    output logic        uart_tx_o,
    output logic        fini_o,
    output logic [31:0] chars_o
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          fin_req;
    logic          hit;
    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;
    logic          fin_set;
    tx_state_t     state;
    tx_state_t     state_n;
    logic [BW-1:0] baud;
    logic [BW-1:0] baud_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_n;
    logic [7:0]    shift;
    logic [7:0]    shift_n;
    logic          tx_n;
    logic          addr_unused;

    assign addr_unused = ^dbus_addr_i[30:0];

    assign hit     = dbus_wvalid_i && dbus_addr_i[31];
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign stall_o = hit && full && !fin_req;
    assign accept  = hit && !full && !fin_req;
    assign fin_set = accept && (dbus_wdata_i == FINISH_CODE);
    assign push    = accept && (dbus_wdata_i != FINISH_CODE);

    // Serializer: line level is registered from the next state so it moves with the state
    always_comb begin
        state_n   = state;
        baud_n    = baud + 1'b1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                end
            end
            START: begin
                if (baud == BAUD_LAST) begin
                    baud_n    = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_n = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            baud      <= '0;
            bit_idx   <= '0;
            uart_tx_o <= 1'b1;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            fin_req   <= 1'b0;
            fini_o    <= 1'b0;
            chars_o   <= '0;
        end else begin
            state     <= state_n;
            baud      <= baud_n;
            bit_idx   <= bit_idx_n;
            uart_tx_o <= tx_n;
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                chars_o <= chars_o + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (fin_set) begin
                fin_req <= 1'b1;
            end
            if (fin_req && empty && (state == IDLE)) begin
                fini_o <= 1'b1;
            end
        end
    end

    // Character storage and shifter carry no reset; control state decides when they matter
    always_ff @(posedge clk_i) begin
        shift <= shift_n;
        if (push) begin
            mem[wr_ptr] <= dbus_wdata_i[7:0];
        end
    end

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console: reference UART decoder plus hand-computed timing points.
`timescale 1ns/1ps
module tb_mmio_console;
    localparam int DEPTH = 16;
    localparam int CPB   = 4;
    localparam logic [31:0] FIN = 32'h0002_0000;
    // {stop, 8'h41 MSB..LSB, start}: line levels of one 'A' frame, index 0 first on the wire
    localparam logic [9:0] FRAME_41 = 10'b10_1000_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        stall;
    logic        uart_tx;
    logic        fini;
    logic [31:0] chars;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    byte unsigned rx_q[$];
    int           rx_errs = 0;
    logic         rx_busy = 1'b0;
    int           rx_cnt = 0;
    logic [7:0]   rx_sh = '0;

    mmio_console #(
        .FIFO_DEPTH(DEPTH),
        .CLKS_PER_BIT(CPB),
        .FINISH_CODE(FIN)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .dbus_addr_i(addr),
        .dbus_wvalid_i(wvalid),
        .dbus_wdata_i(wdata),
        .stall_o(stall),
        .uart_tx_o(uart_tx),
        .fini_o(fini),
        .chars_o(chars)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference 8N1 receiver sampling near mid-bit on the falling clock edge
    always @(negedge clk) begin
        if (rst) begin
            rx_busy = 1'b0;
            rx_q.delete();
        end else if (!rx_busy) begin
            if (!uart_tx) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt = rx_cnt + 1;
            if (rx_cnt == 2 && uart_tx) rx_errs++;
            if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2)
                rx_sh[(rx_cnt - 6) / 4] = uart_tx;
            if (rx_cnt == 38) begin
                if (!uart_tx) rx_errs++;
                rx_q.push_back(rx_sh);
                rx_busy = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         output int stalls, output int edge_no);
        @(negedge clk);
        addr = a;
        wdata = d;
        wvalid = 1'b1;
        stalls = 0;
        #1;
        while (stall && stalls < 2000) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        @(posedge clk);
        #1;
        edge_no = cyc;
        wvalid = 1'b0;
    endtask

    task automatic watch_high(input int n, output logic hi);
        hi = 1'b1;
        repeat (n) begin
            @(negedge clk);
            hi &= uart_tx;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        int e0;
        int e;
        int ef;
        int bad;
        int st18;
        int e18;
        logic hi;
        logic [39:0] wave;
        logic [39:0] exp_wave;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_tx", 64'(uart_tx), 64'd1);
        check("rst_fini", 64'(fini), 64'd0);
        check("rst_chars", 64'(chars), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);

        // Stores outside the console window are ignored
        store(32'h0000_1000, 32'h0000_0041, st, e);
        store(32'h7FFF_FFFC, FIN, st, e);
        watch_high(60, hi);
        check("nohit_line", 64'(hi), 64'd1);
        check("nohit_chars", 64'(chars), 64'd0);
        check("nohit_fini", 64'(fini), 64'd0);
        check("nohit_rx", 64'(rx_q.size()), 64'd0);

        // Single 'A' frame, exact waveform
        store(32'h8000_0000, 32'h0000_0041, st, e0);
        check("t1_lat", 64'(uart_tx), 64'd1);
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            wave[k] = uart_tx;
            exp_wave[k] = FRAME_41[k / 4];
        end
        check("t1_wave", 64'(wave), 64'(exp_wave));
        @(negedge clk);
        check("t1_idle", 64'(uart_tx), 64'd1);
        check("t1_chars", 64'(chars), 64'd1);
        check("t1_rx_n", 64'(rx_q.size()), 64'd1);
        if (rx_q.size() > 0) check("t1_rx_byte", 64'(rx_q[0]), 64'h41);

        // 18 back-to-back stores against a 16-deep FIFO
        reset_dut();
        bad = 0;
        for (int i = 0; i < 17; i++) begin
            store(32'h8000_0000 | 32'(i * 4), 32'hDEAD_0030 + 32'(i), st, e);
            if (i == 0) e0 = e;
            if (st != 0 || e != e0 + i) bad++;
        end
        check("fill_nostall", 64'(bad), 64'd0);
        store(32'h8000_0044, 32'hDEAD_0041, st18, e18);
        check("fill_stall_len", 64'(st18), 64'd25);
        check("fill_accept_edge", 64'(e18 - e0), 64'd42);
        for (int w = 0; w < 1000 && rx_q.size() < 18; w++) @(posedge clk);
        repeat (50) @(posedge clk);
        check("fill_rx_n", 64'(rx_q.size()), 64'd18);
        for (int i = 0; i < 18 && i < rx_q.size(); i++)
            check($sformatf("fill_rx_%0d", i), 64'(rx_q[i]), 64'(8'h30 + 8'(i)));
        check("fill_chars", 64'(chars), 64'd18);

        // Finish waits for queued characters to drain
        reset_dut();
        store(32'h8000_0000, 32'h0000_0068, st, e0);
        store(32'h8000_0000, 32'h0000_0069, st, e);
        store(32'h8000_0000, FIN, st, e);
        check("fin_nostall", 64'(st), 64'd0);
        check("fin_early", 64'(fini), 64'd0);
        ef = -1;
        for (int w = 0; w < 200; w++) begin
            @(posedge clk);
            #1;
            if (fini) begin
                ef = cyc;
                break;
            end
        end
        check("fin_rise_edge", 64'(ef - e0), 64'd82);
        check("fin_chars", 64'(chars), 64'd2);
        check("fin_rx_n", 64'(rx_q.size()), 64'd2);
        if (rx_q.size() >= 2) begin
            check("fin_rx_h", 64'(rx_q[0]), 64'h68);
            check("fin_rx_i", 64'(rx_q[1]), 64'h69);
        end
        store(32'h8000_0000, 32'h0000_0041, st, e);
        check("post_fin_nostall", 64'(st), 64'd0);
        watch_high(60, hi);
        check("post_fin_line", 64'(hi), 64'd1);
        check("post_fin_chars", 64'(chars), 64'd2);
        check("post_fin_fini", 64'(fini), 64'd1);

        // Finish while already idle and empty
        reset_dut();
        store(32'h8000_0000, FIN, st, e);
        check("fin_idle_now", 64'(fini), 64'd0);
        @(posedge clk);
        #1;
        check("fin_idle_next", 64'(fini), 64'd1);

        // Reset in the middle of a frame with bytes queued
        reset_dut();
        for (int i = 0; i < 4; i++) store(32'h8000_0000, 32'h0000_0000, st, e);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("mid_rst_pre", 64'(uart_tx), 64'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_line", 64'(uart_tx), 64'd1);
        check("mid_rst_chars", 64'(chars), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        watch_high(120, hi);
        check("mid_rst_quiet", 64'(hi), 64'd1);
        check("mid_rst_chars2", 64'(chars), 64'd0);
        check("mid_rst_rx", 64'(rx_q.size()), 64'd0);
        check("rx_framing", 64'(rx_errs), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_console.md
# mmio_console

Synthesizable memory-mapped console and simulation-exit device sitting directly downstream of the CPU data bus in `main`. It captures stores to the console window (address bit 31 set), queues the low byte of each store in a FIFO, serializes queued bytes on an 8N1 UART line, and recognizes the exit code 0x00020000. On that code it raises a finish flag only once every previously queued character has left the wire. Benches and on-board hardware share one console path.

## Interface
- `FIFO_DEPTH`, 16: character FIFO entries; power of two, ≥2.
- `CLKS_PER_BIT`, 100: clock cycles per UART bit; ≥2.
- `FINISH_CODE`, 32'h00020000: store data value that requests finish instead of printing.
- `clk_i`  in  1: single clock; all state on rising edge.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `dbus_addr_i`  in  32: CPU store address.
- `dbus_wvalid_i`  in  1: CPU store strobe, one cycle per store.
- `dbus_wdata_i`  in  32: CPU store data.
- `stall_o`  out  1: combinational; holds the CPU store while the console cannot accept it.
- `uart_tx_o`  out  1: registered serial output; idle high.
- `fini_o`  out  1: registered; sticky finish indication.
- `chars_o`  out  32: registered count of bytes accepted into the FIFO.

## Operation
- Console hit: `dbus_wvalid_i && dbus_addr_i[31]`. Stores with bit 31 clear are ignored, with no effect on any output.
- `stall_o` = hit && FIFO full && !fin_req.
- Accept rule: hit && !stall_o && !fin_req.
  - If `dbus_wdata_i == FINISH_CODE`, set internal `fin_req`; nothing is queued.
  - Otherwise push `dbus_wdata_i[7:0]` and increment `chars_o`, which wraps at 2^32.
- Once `fin_req` is set, every later hit is dropped silently and `stall_o` stays 0.
- FIFO:
  - Circular buffer with read/write pointers and a count of width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - Full and empty decode from the registered count. A push in the same cycle as a pop is still refused when the count equals FIFO_DEPTH.
  - A push and a pop in the same cycle leave the count unchanged.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: `uart_tx_o`=1. If the FIFO is not empty, pop into the shift register and go to START.
  - START: `uart_tx_o`=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: `uart_tx_o`=shift[0] for CLKS_PER_BIT cycles per bit, LSB first, shifting right after each bit. After bit 7 go to STOP.
  - STOP: `uart_tx_o`=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is not empty, pop and go to START with no idle gap; otherwise go to IDLE.
  - The baud counter runs 0..CLKS_PER_BIT-1 and is cleared on every state change.
- Finish: `fini_o` sets when `fin_req` && FIFO empty && FSM in IDLE. It then stays high until reset.

## Timing
- Reset values: `uart_tx_o`=1, `fini_o`=0, `chars_o`=0, FIFO empty, FSM IDLE, `fin_req`=0. `stall_o` is therefore 0.
- Reset asserted mid-frame returns the line high immediately (asynchronous) and discards all queued bytes.
- Push at edge N: the count is visible after N. When idle, the pop happens at edge N+1 and `uart_tx_o` falls from N+1 (latency 1 cycle).
- One frame lasts exactly 10×CLKS_PER_BIT cycles; frames are back-to-back while data remains.
- `stall_o` follows the inputs in the same cycle. The CPU holds addr/data/wvalid until `stall_o` drops. A stalled store is accepted in the first cycle the count drops below FIFO_DEPTH, which is the cycle after a pop.
- `fini_o` rises at the edge after the FSM re-enters IDLE with the FIFO empty. If `fin_req` arrives while already idle and empty, it rises one cycle after the finish store.

## Test plan
- CLKS_PER_BIT=4, store 0x80000000 ← 0x41 → `uart_tx_o` shows 0,1,0,0,0,0,0,1,0,1, each held 4 cycles, 40 cycles total. `chars_o`=1.
- Store 0x00001000 ← 0x41 and 0x7FFFFFFC ← 0x00020000 → line stays 1, `chars_o`=0, `fini_o`=0.
- FIFO_DEPTH=16: 18 consecutive hit stores → the first 17 are accepted (1 popped immediately plus 16 queued). The 18th sees `stall_o`=1 until one cycle after the second pop, then is accepted. All 18 bytes appear in order; `chars_o`=18.
- Store "h", "i", then 0x00020000 → no stall on the finish store. `fini_o` stays 0 through both frames and rises one cycle after the STOP of "i". `chars_o`=2. A later store of 0x41 changes nothing.
- Finish store with an empty FIFO and idle FSM → `fini_o`=1 on the next cycle.
- Assert `rst_i` during DATA of a frame with 3 bytes queued → `uart_tx_o`=1 at once. After release: count 0, `chars_o`=0, no further frames.
